// File: rtl/cordic_mac_datapath.sv
// Linear-mode CORDIC multiply-accumulate datapath: y_out = y_in + x_in * z_in.
// It applies one shift/add micro-rotation per clock under the control of an external
// iteration controller. That controller supplies iter/stop and observes the residual Zn.
module cordic_mac_datapath #(
  parameter int W     = 16,
  parameter int FRAC  = 12,
  parameter int GUARD = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] x_in,
  input  logic [W-1:0] y_in,
  input  logic [W-1:0] z_in,
  input  logic [2:0]   iter,
  input  logic         stop,
  output logic [W-1:0] Zn,
  output logic [W-1:0] y_out,
  output logic         busy,
  output logic         done
);

  localparam int AW = W + GUARD;
  localparam logic [W-1:0] ONE = W'(1) << FRAC;
  localparam logic [W-1:0] POS_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] NEG_MAX = {1'b1, {(W-1){1'b0}}};

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state;
  logic signed [W-1:0]  x_r;
  logic signed [W-1:0]  z;
  logic signed [AW-1:0] y_acc;

  logic signed [AW-1:0] x_step;
  logic signed [W-1:0]  z_step;
  logic [W-1:0]         y_sat;
  logic                 z_neg;

  // Per-iteration increments and the saturated view of the accumulator.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    x_step = '0;
    z_step = '0;
    y_sat  = y_acc[W-1:0];
    z_neg  = z[W-1];
    // The guard bits sign-extend x_r before the arithmetic shift.
    x_step = $signed({{GUARD{x_r[W-1]}}, x_r}) >>> iter;
    z_step = $signed(ONE >> iter);
    // If the guard bits and the W-bit sign bit disagree, the value does not fit in W bits.
    if (y_acc[AW-1:W-1] != {(GUARD+1){y_acc[W-1]}})
      y_sat = y_acc[AW-1] ? NEG_MAX : POS_MAX;
  end

  assign Zn = z;

  // Control state, operand capture, micro-rotation and result hand-off.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so that all registers update together.
    if (rst) begin
      state <= IDLE;
      x_r   <= '0;
      z     <= '0;
      y_acc <= '0;
      y_out <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (load) begin
            x_r   <= x_in;
            z     <= z_in;
            y_acc <= $signed({{GUARD{y_in[W-1]}}, y_in});
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (stop) begin
            y_out <= y_sat;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else if (z_neg) begin
            y_acc <= y_acc - x_step;
            z     <= z + z_step;
          end else begin
            y_acc <= y_acc + x_step;
            z     <= z - z_step;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_mac_datapath.sv
// Self-checking bench for cordic_mac_datapath. It includes a small iteration controller and
// an arithmetic reference model of the linear CORDIC multiply-accumulate.
module tb_cordic_mac_datapath;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] x_in, y_in, z_in;
  logic [2:0]  iter;
  logic        stop;
  logic        stop_force;
  logic [15:0] Zn, y_out;
  logic        busy, done;

  int n_checks = 0;
  int n_pass   = 0;

  cordic_mac_datapath dut (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .x_in  (x_in),
    .y_in  (y_in),
    .z_in  (z_in),
    .iter  (iter),
    .stop  (stop),
    .Zn    (Zn),
    .y_out (y_out),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  // Controller: iter is 0 on the first RUN edge and advances once for each applied rotation.
  // stop is raised when iter reaches 7 or when the residual reaches zero.
  assign stop = stop_force | (iter == 3'd7) | (Zn == 16'h0000);

  always @(posedge clk or posedge rst) begin
    if (rst)       iter <= 3'd0;
    else if (!busy) iter <= 3'd0;
    else if (!stop) iter <= iter + 3'd1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
  endtask

  // Reference: at most 7 rotations (i = 0..6), and it stops early once the residual is zero.
  // Saturation then clamps the result to the 16-bit signed range.
  task automatic ref_mac(input int x, input int y, input int z,
                         output int res, output int n, output int zf);
    int ya = y;
    int zz = z;
    n = 0;
    for (int i = 0; i < 7; i++) begin
      if (zz == 0) break;
      if (zz >= 0) begin ya += (x >>> i); zz -= (4096 >> i); end
      else         begin ya -= (x >>> i); zz += (4096 >> i); end
      n++;
    end
    if (ya > 32767)       res = 32767;
    else if (ya < -32768) res = -32768;
    else                  res = ya;
    zf = zz;
  endtask

  // Runs one operation. If disturb >= 0, a competing load is driven before RUN edge disturb+1.
  task automatic run_op(input logic signed [15:0] x, input logic signed [15:0] y,
                        input logic signed [15:0] z, input int disturb);
    int  ey, en, ez, lat;
    bit  seen;
    ref_mac(int'(x), int'(y), int'(z), ey, en, ez);
    @(negedge clk);
    x_in = x; y_in = y; z_in = z; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    check("busy_after_load", int'(busy), 1);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      if (lat == disturb) begin
        @(negedge clk);
        load = 1'b1; x_in = 16'h1234; y_in = 16'h4321; z_in = 16'h0100;
      end
      @(posedge clk); #1;
      load = 1'b0;
      lat++;
      seen = done;
    end
    check("done_seen", int'(seen), 1);
    check("latency", lat, en + 1);
    check("y_out", int'($signed(y_out)), ey);
    check("zn_final", int'($signed(Zn)), ez);
    check("busy_after_done", int'(busy), 0);
    @(posedge clk); #1;
    check("done_one_cycle", int'(done), 0);
    check("idle_after_done", int'(busy), 0);
  endtask

  initial begin
    int ex, err;
    logic signed [15:0] rx, ry, rz;
    rst = 1'b1; load = 1'b0; stop_force = 1'b0;
    x_in = '0; y_in = '0; z_in = '0;
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_y_out", int'(y_out), 0);
    check("rst_zn", int'(Zn), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // 0.5 * 0.75: exact exit after 3 rotations.
    run_op(16'sh0800, 16'sh0000, 16'sh0C00, -1);
    check("dir_mul", int'(y_out), 16'h0600);
    run_op(16'sh0800, 16'sh1000, 16'sh0C00, -1);
    check("dir_mac", int'(y_out), 16'h1600);
    // A zero multiplier takes no rotations and passes the seed through.
    run_op(16'sh0800, 16'sh0123, 16'sh0000, -1);
    check("dir_zero_z", int'(y_out), 16'h0123);
    // Saturation in both directions.
    run_op(16'sh7FFF, 16'sh7000, 16'sh1000, -1);
    check("sat_pos", int'(y_out), 16'h7FFF);
    run_op(-16'sh8000, -16'sh8000, 16'sh1000, -1);
    check("sat_neg", int'(y_out), 16'h8000);
    // No exact exit: all 7 iterations are used, and the error stays within |x|>>6.
    run_op(16'sh1000, 16'sh0000, 16'sh0555, -1);
    ex  = (4096 * 16'sh0555) >>> 12;
    err = int'($signed(y_out)) - ex;
    if (err < 0) err = -err;
    check("residual_bound", int'(err <= (4096 >> 6)), 1);
    // A load arriving mid-run or on the done edge must be ignored.
    run_op(16'sh0800, 16'sh0000, 16'sh0555, 2);
    run_op(16'sh0800, 16'sh0000, 16'sh0C00, 3);

    // A stop while idle must not produce done.
    @(negedge clk) stop_force = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("idle_stop_done", int'(done), 0);
    end
    check("idle_stop_busy", int'(busy), 0);
    @(negedge clk) stop_force = 1'b0;

    // Reset mid-operation clears everything immediately.
    @(negedge clk);
    x_in = 16'h0800; y_in = 16'h0100; z_in = 16'h0555; load = 1'b1;
    @(posedge clk); #1 load = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_zn", int'(Zn), 0);
    check("midrst_y_out", int'(y_out), 0);
    check("midrst_done", int'(done), 0);
    @(negedge clk) rst = 1'b0;

    // Randomized operands with z in [-2.0, 2.0).
    for (int k = 0; k < 40; k++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      rz = 16'($signed(int'($urandom_range(0, 16383)) - 8192));
      if (k % 8 == 0) rz = 16'sh0000;
      run_op(rx, ry, rz, (k % 5 == 0) ? int'($urandom_range(0, 3)) : -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
